// File: rtl/avaliador_polinomio.sv
// avaliador_polinomio
// Evaluates P(X) = sum COEF[i]*X^i, i=0..GRAU, with Horner's method: one
// multiply-add per clock. A small three-state FSM (IDLE, CALC, DONE) drives
// the datapath. The result and the overflow flag are held until the next
// accepted start.
module avaliador_polinomio #(
   parameter int W    = 16,
   parameter int GRAU = 2
) (
   input  logic                  ck,
   input  logic                  rst,
   input  logic                  inicio,
   input  logic                  pronto,
   input  logic [W-1:0]          X,
   input  logic [(GRAU+1)*W-1:0] COEF,
   output logic [W-1:0]          Resultado,
   output logic                  LED,
   output logic                  ocupado,
   output logic                  estouro
);

   // cnt counts down from GRAU to 1, so it must be able to hold GRAU itself.
   localparam int CW = (GRAU > 1) ? $clog2(GRAU + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } estado_t;

   estado_t        estado;
   estado_t        proximo;

   logic [W-1:0]   acc;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   xreg;
   logic [W-1:0]   coefreg [0:GRAU];

   logic [CW-1:0]  indice;
   logic [W-1:0]   coefatual;
   logic [2*W-1:0] prod;
   logic [2*W:0]   soma;
   logic           passoestouro;
   logic           ultimopasso;

   // Horner step datapath. The product is formed at full 2W width and the sum
   // at 2W+1 width, so that any carry into the upper bits can be flagged
   // before the result is truncated back to W bits.
   always_comb begin
      indice       = cnt - CW'(1);
      coefatual    = coefreg[indice];
      prod         = (2*W)'(acc) * (2*W)'(xreg);
      soma         = {1'b0, prod} + (2*W+1)'(coefatual);
      passoestouro = (|prod[2*W-1:W]) | (|soma[2*W:W]);
      ultimopasso  = (cnt == CW'(1));
   end

   // State register. Reset is synchronous and has priority over every other input.
   always_ff @(posedge ck) begin
      if (rst) begin
         estado <= IDLE;
      end else begin
         estado <= proximo;
      end
   end

   // Next-state logic. inicio only matters in IDLE and pronto only in DONE,
   // so a held inicio cannot retrigger a run and an early pronto cannot skip DONE.
   always_comb begin
      proximo = estado;
      case (estado)
         IDLE: begin
            if (inicio) begin
               proximo = CALC;
            end
         end
         CALC: begin
            if (ultimopasso) begin
               proximo = DONE;
            end
         end
         DONE: begin
            if (pronto) begin
               proximo = IDLE;
            end
         end
         default: begin
            proximo = IDLE;
         end
      endcase
   end

   // Datapath registers. Operands are captured when a start is accepted, so
   // later changes on X/COEF do not disturb a running evaluation. Resultado is
   // only written on the final step, so an aborted run never exposes a partial value.
   always_ff @(posedge ck) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         xreg      <= '0;
         Resultado <= '0;
         estouro   <= 1'b0;
         for (int i = 0; i <= GRAU; i++) begin
            coefreg[i] <= '0;
         end
      end else begin
         case (estado)
            IDLE: begin
               if (inicio) begin
                  xreg    <= X;
                  acc     <= COEF[GRAU*W +: W];
                  cnt     <= CW'(GRAU);
                  estouro <= 1'b0;
                  for (int i = 0; i <= GRAU; i++) begin
                     coefreg[i] <= COEF[i*W +: W];
                  end
               end
            end
            CALC: begin
               acc <= soma[W-1:0];
               cnt <= cnt - CW'(1);
               if (passoestouro) begin
                  estouro <= 1'b1;
               end
               if (ultimopasso) begin
                  Resultado <= soma[W-1:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      ocupado = (estado == CALC);
      LED     = (estado == DONE);
   end

endmodule

// File: tb/tb_avaliador_polinomio.sv
// Testbench for avaliador_polinomio (W=16, GRAU=2).
// Directed scenarios plus randomized runs, all checked against a reference
// model that evaluates the polynomial as a plain sum of powers.
module tb_avaliador_polinomio;

   localparam int W    = 16;
   localparam int GRAU = 2;
   localparam int CW   = (GRAU + 1) * W;

   logic          ck = 1'b0;
   logic          rst;
   logic          inicio;
   logic          pronto;
   logic [W-1:0]  X;
   logic [CW-1:0] COEF;
   logic [W-1:0]  Resultado;
   logic          LED;
   logic          ocupado;
   logic          estouro;

   int checks   = 0;
   int failures = 0;

   avaliador_polinomio #(.W(W), .GRAU(GRAU)) dut (
      .ck        (ck),
      .rst       (rst),
      .inicio    (inicio),
      .pronto    (pronto),
      .X         (X),
      .COEF      (COEF),
      .Resultado (Resultado),
      .LED       (LED),
      .ocupado   (ocupado),
      .estouro   (estouro)
   );

   always #5 ck = ~ck;

   // Advance one rising edge, then settle so that inputs and outputs are
   // handled away from the edge.
   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   // Reference value: sum of COEF[i]*X^i with each term reduced mod 2^W.
   function automatic logic [W-1:0] ref_value(input logic [W-1:0] x, input logic [CW-1:0] c);
      longint unsigned total = 0;
      longint unsigned pw    = 1;
      longint unsigned mask  = (64'd1 << W) - 1;
      for (int i = 0; i <= GRAU; i++) begin
         total = (total + longint'(c[i*W +: W]) * pw) & mask;
         pw    = (pw * longint'(x)) & mask;
      end
      return total[W-1:0];
   endfunction

   // Reference overflow: nested evaluation with unbounded intermediates,
   // flagging any product or sum that does not fit in W bits.
   function automatic logic ref_overflow(input logic [W-1:0] x, input logic [CW-1:0] c);
      longint unsigned lim = (64'd1 << W);
      longint unsigned a   = longint'(c[GRAU*W +: W]);
      longint unsigned p;
      longint unsigned s;
      logic ov = 1'b0;
      for (int i = GRAU - 1; i >= 0; i--) begin
         p = a * longint'(x);
         s = p + longint'(c[i*W +: W]);
         if (p >= lim || s >= lim) ov = 1'b1;
         a = s % lim;
      end
      return ov;
   endfunction

   // Pulse inicio for one edge, then wait (bounded) for LED. Reports how many
   // edges after acceptance LED rose and how many cycles ocupado was seen high.
   task automatic applyStimulus(input logic [W-1:0] x, input logic [CW-1:0] c,
                                output int latencia, output int ciclosocupado);
      X      = x;
      COEF   = c;
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      latencia      = 0;
      ciclosocupado = 0;
      while (LED !== 1'b1 && latencia < 100) begin
         if (ocupado === 1'b1) ciclosocupado++;
         tick();
         latencia++;
      end
   endtask

   // Acknowledge the result with a one-cycle pronto pulse.
   task automatic acknowledge();
      pronto = 1'b1;
      tick();
      pronto = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if (Resultado !== '0) begin failures++; $display("[TB] FAIL reset_resultado got=%0d exp=0", Resultado); end
      checks++;
      if (LED !== 1'b0) begin failures++; $display("[TB] FAIL reset_led got=%b exp=0", LED); end
      checks++;
      if (ocupado !== 1'b0) begin failures++; $display("[TB] FAIL reset_ocupado got=%b exp=0", ocupado); end
      checks++;
      if (estouro !== 1'b0) begin failures++; $display("[TB] FAIL reset_estouro got=%b exp=0", estouro); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ocupado !== 1'b0 || LED !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle_hold ocupado=%b led=%b exp=0,0", ocupado, LED);
         end
      end
   endtask

   task automatic test_basic();
      int lat, busy;
      applyStimulus(16'd2, {16'd1, 16'd3, 16'd4}, lat, busy);
      checks++;
      if (lat !== GRAU) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", lat, GRAU); end
      checks++;
      if (busy !== GRAU) begin failures++; $display("[TB] FAIL basic_busy_cycles got=%0d exp=%0d", busy, GRAU); end
      checks++;
      if (Resultado !== 16'd14) begin failures++; $display("[TB] FAIL basic_resultado got=%0d exp=14", Resultado); end
      checks++;
      if (estouro !== 1'b0) begin failures++; $display("[TB] FAIL basic_estouro got=%b exp=0", estouro); end
   endtask

   task automatic test_hold_done();
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (LED !== 1'b1 || Resultado !== 16'd14) begin
            failures++;
            $display("[TB] FAIL hold_done cycle=%0d led=%b res=%0d exp=1,14", i, LED, Resultado);
         end
      end
      acknowledge();
      checks++;
      if (LED !== 1'b0) begin failures++; $display("[TB] FAIL hold_ack_led got=%b exp=0", LED); end
      checks++;
      if (Resultado !== 16'd14) begin failures++; $display("[TB] FAIL hold_keep_resultado got=%0d exp=14", Resultado); end
   endtask

   task automatic test_overflow();
      int lat, busy;
      applyStimulus(16'h0100, {16'd1, 16'd0, 16'd0}, lat, busy);
      checks++;
      if (Resultado !== 16'h0000) begin failures++; $display("[TB] FAIL ovf_resultado got=%h exp=0000", Resultado); end
      checks++;
      if (estouro !== 1'b1) begin failures++; $display("[TB] FAIL ovf_estouro got=%b exp=1", estouro); end
      acknowledge();
      applyStimulus(16'd3, {16'd1, 16'd3, 16'd4}, lat, busy);
      checks++;
      if (Resultado !== 16'd22) begin failures++; $display("[TB] FAIL ovf_clear_resultado got=%0d exp=22", Resultado); end
      checks++;
      if (estouro !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear_estouro got=%b exp=0", estouro); end
      acknowledge();
   endtask

   task automatic test_back_to_back();
      int n;
      int busy;
      X      = 16'd2;
      COEF   = {16'd1, 16'd3, 16'd4};
      inicio = 1'b1;
      tick();
      // Change operands mid-run: the running evaluation must not see them.
      X    = 16'd3;
      n    = 0;
      while (LED !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (Resultado !== 16'd14) begin failures++; $display("[TB] FAIL b2b_registered_inputs got=%0d exp=14", Resultado); end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (LED !== 1'b1 || ocupado !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_no_retrigger led=%b ocupado=%b exp=1,0", LED, ocupado);
         end
      end
      pronto = 1'b1;
      tick();
      pronto = 1'b0;
      checks++;
      if (LED !== 1'b0 || ocupado !== 1'b0) begin
         failures++;
         $display("[TB] FAIL b2b_done_to_idle led=%b ocupado=%b exp=0,0", LED, ocupado);
      end
      tick();
      inicio = 1'b0;
      checks++;
      if (ocupado !== 1'b1) begin failures++; $display("[TB] FAIL b2b_restart ocupado=%b exp=1", ocupado); end
      n    = 0;
      busy = 0;
      while (LED !== 1'b1 && n < 100) begin
         if (ocupado === 1'b1) busy++;
         tick();
         n++;
      end
      checks++;
      if (busy !== GRAU) begin failures++; $display("[TB] FAIL b2b_busy_cycles got=%0d exp=%0d", busy, GRAU); end
      checks++;
      if (Resultado !== 16'd22) begin failures++; $display("[TB] FAIL b2b_second_resultado got=%0d exp=22", Resultado); end
      acknowledge();
   endtask

   task automatic test_reset_mid_calc();
      int lat, busy;
      X      = 16'h0100;
      COEF   = {16'h0100, 16'd0, 16'd7};
      inicio = 1'b1;
      tick();
      inicio = 1'b0;
      rst    = 1'b1;
      tick();
      rst    = 1'b0;
      checks++;
      if (Resultado !== '0 || LED !== 1'b0 || ocupado !== 1'b0 || estouro !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_outputs res=%0d led=%b ocupado=%b estouro=%b exp=0,0,0,0",
                  Resultado, LED, ocupado, estouro);
      end
      tick();
      checks++;
      if (ocupado !== 1'b0 || LED !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midrst_stays_idle ocupado=%b led=%b exp=0,0", ocupado, LED);
      end
      applyStimulus(16'd0, {16'd1, 16'd3, 16'd4}, lat, busy);
      checks++;
      if (Resultado !== 16'd4) begin failures++; $display("[TB] FAIL midrst_new_run got=%0d exp=4", Resultado); end
      acknowledge();
   endtask

   task automatic checkOutput();
      int lat, busy;
      logic [W-1:0]  x;
      logic [CW-1:0] c;
      for (int k = 0; k < 24; k++) begin
         if (k % 2 == 0) begin
            x = W'($urandom_range(0, 15));
            for (int i = 0; i <= GRAU; i++) c[i*W +: W] = W'($urandom_range(0, 40));
         end else begin
            x = W'($urandom);
            for (int i = 0; i <= GRAU; i++) c[i*W +: W] = W'($urandom);
         end
         applyStimulus(x, c, lat, busy);
         checks++;
         if (lat !== GRAU || busy !== GRAU) begin
            failures++;
            $display("[TB] FAIL rand_timing run=%0d lat=%0d busy=%0d exp=%0d", k, lat, busy, GRAU);
         end
         checks++;
         if (Resultado !== ref_value(x, c)) begin
            failures++;
            $display("[TB] FAIL rand_resultado run=%0d x=%h got=%h exp=%h", k, x, Resultado, ref_value(x, c));
         end
         checks++;
         if (estouro !== ref_overflow(x, c)) begin
            failures++;
            $display("[TB] FAIL rand_estouro run=%0d x=%h got=%b exp=%b", k, x, estouro, ref_overflow(x, c));
         end
         acknowledge();
      end
   endtask

   // Scenario sequence.
   initial begin
      rst    = 1'b1;
      inicio = 1'b0;
      pronto = 1'b0;
      X      = '0;
      COEF   = '0;
      test_reset();
      test_basic();
      test_hold_done();
      test_overflow();
      test_back_to_back();
      test_reset_mid_calc();
      checkOutput();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
